// File: rtl/core_inst_sequencer.sv
// Sequences the core's 34-bit inst word through a full 3x3 convolution pass:
// per-kij weight/activation loads, execute, drain, OFIFO->pmem, then accumulation reads.
module core_inst_sequencer #(
    parameter int COL      = 8,
    parameter int ROW      = 8,
    parameter int LEN_NIJ  = 36,
    parameter int NIJ_W    = 6,
    parameter int LEN_ONIJ = 16,
    parameter int ONIJ_W   = 4,
    parameter int LEN_KIJ  = 9,
    parameter int KIJ_W    = 3,
    parameter int W_BASE   = 1024,
    parameter int GAP      = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_ofifo_valid,
    output logic [33:0] o_inst,
    output logic        o_acc_clr,
    output logic        o_out_valid,
    output logic [4:0]  o_onij_idx,
    output logic [3:0]  o_kij_idx,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
    localparam int B_ACC   = 33;
    localparam int B_CEN_P = 32;
    localparam int B_WEN_P = 31;
    localparam int AP_HI   = 30;
    localparam int AP_LO   = 20;
    localparam int B_CEN_X = 19;
    localparam int AX_HI   = 17;
    localparam int AX_LO   = 7;
    localparam int B_OFRD  = 6;
    localparam int B_L0RD  = 3;
    localparam int B_L0WR  = 2;
    localparam int B_EXEC  = 1;
    localparam int B_LOAD  = 0;

    typedef enum logic [3:0] {
        S_IDLE, S_W_L0, S_W_LD, S_GAP, S_A_L0, S_EXEC,
        S_DRAIN, S_OF_WAIT, S_OF_RD, S_ACC, S_DONE
    } state_t;

    state_t      r_state, w_state;
    logic [6:0]  r_t, w_t;
    logic [3:0]  r_kij, w_kij;
    logic [4:0]  r_o, w_o;
    logic [3:0]  r_p, w_p;
    logic        r_wr_pend, w_wr_pend;

    logic [33:0] r_inst, w_inst;
    logic        r_acc_clr, w_acc_clr;
    logic        r_out_valid, w_out_valid;
    logic [4:0]  r_onij_idx;
    logic [3:0]  r_kij_idx;
    logic        r_busy, w_busy;
    logic        r_done, w_done;

    int          w_k;
    int          w_oi;
    logic [10:0] w_acc_addr;

    // ACC phase p=1..LEN_KIJ reads tap k=p-1 of output r_o
    always_comb begin
        w_k        = (r_p == '0) ? 0 : int'(r_p) - 1;
        w_oi       = int'(r_o);
        w_acc_addr = 11'(w_k * LEN_NIJ + (w_oi / ONIJ_W + w_k / KIJ_W) * NIJ_W
                         + (w_oi % ONIJ_W + w_k % KIJ_W));
    end

    always_comb begin
        w_state     = r_state;
        w_t         = r_t + 7'd1;
        w_kij       = r_kij;
        w_o         = r_o;
        w_p         = r_p;
        w_wr_pend   = 1'b0;
        w_inst      = IDLE_WORD;
        w_acc_clr   = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_t = '0;
                if (i_start) begin
                    w_state = S_W_L0;
                    w_kij   = '0;
                    w_o     = '0;
                    w_p     = '0;
                    w_busy  = 1'b1;
                end
            end
            // SRAM read latency is one cycle: reads on t<COL, L0 writes on t=1..COL
            S_W_L0: begin
                w_inst[AX_HI:AX_LO] = 11'(W_BASE + int'(r_kij) * COL + int'(r_t));
                if (int'(r_t) < COL) w_inst[B_CEN_X] = 1'b0;
                if (r_t != '0)       w_inst[B_L0WR]  = 1'b1;
                if (int'(r_t) == COL) begin
                    w_state = S_W_LD;
                    w_t     = '0;
                end
            end
            S_W_LD: begin
                w_inst[B_L0RD] = 1'b1;
                w_inst[B_LOAD] = 1'b1;
                if (int'(r_t) == COL - 1) begin
                    w_state = S_GAP;
                    w_t     = '0;
                end
            end
            S_GAP: begin
                if (int'(r_t) == GAP - 1) begin
                    w_state = S_A_L0;
                    w_t     = '0;
                end
            end
            S_A_L0: begin
                w_inst[AX_HI:AX_LO] = 11'(r_t);
                if (int'(r_t) < LEN_NIJ) w_inst[B_CEN_X] = 1'b0;
                if (r_t != '0)           w_inst[B_L0WR]  = 1'b1;
                if (int'(r_t) == LEN_NIJ) begin
                    w_state = S_EXEC;
                    w_t     = '0;
                end
            end
            S_EXEC: begin
                w_inst[B_EXEC] = 1'b1;
                w_inst[B_L0RD] = 1'b1;
                if (int'(r_t) == LEN_NIJ - 1) begin
                    w_state = S_DRAIN;
                    w_t     = '0;
                end
            end
            S_DRAIN: begin
                if (int'(r_t) == ROW + COL - 1) begin
                    w_state = S_OF_WAIT;
                    w_t     = '0;
                end
            end
            S_OF_WAIT: begin
                w_t = '0;
                if (i_ofifo_valid) w_state = S_OF_RD;
            end
            // r_t counts accepted reads; the write for read n lands while r_t==n+1
            S_OF_RD: begin
                w_t = r_t;
                if (r_wr_pend) begin
                    w_inst[B_CEN_P]     = 1'b0;
                    w_inst[B_WEN_P]     = 1'b0;
                    w_inst[AP_HI:AP_LO] = 11'(int'(r_kij) * LEN_NIJ + int'(r_t) - 1);
                end
                if (int'(r_t) == LEN_NIJ) begin
                    w_t = '0;
                    if (int'(r_kij) == LEN_KIJ - 1) begin
                        w_state = S_ACC;
                    end else begin
                        w_state = S_W_L0;
                        w_kij   = r_kij + 4'd1;
                    end
                end else if (i_ofifo_valid) begin
                    w_inst[B_OFRD] = 1'b1;
                    w_t            = r_t + 7'd1;
                    w_wr_pend      = 1'b1;
                end
            end
            S_ACC: begin
                w_t = '0;
                w_p = r_p + 4'd1;
                if (r_p == '0) w_acc_clr = 1'b1;
                if (r_p != '0 && int'(r_p) <= LEN_KIJ) begin
                    w_inst[B_CEN_P]     = 1'b0;
                    w_inst[AP_HI:AP_LO] = w_acc_addr;
                end
                if (int'(r_p) >= 2 && int'(r_p) <= LEN_KIJ + 1) w_inst[B_ACC] = 1'b1;
                if (int'(r_p) == LEN_KIJ + 2) begin
                    w_out_valid = 1'b1;
                    w_p         = '0;
                    if (int'(r_o) == LEN_ONIJ - 1) w_state = S_DONE;
                    else                           w_o     = r_o + 5'd1;
                end
            end
            S_DONE: begin
                w_t     = '0;
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_t         <= '0;
            r_kij       <= '0;
            r_o         <= '0;
            r_p         <= '0;
            r_wr_pend   <= 1'b0;
            r_inst      <= IDLE_WORD;
            r_acc_clr   <= 1'b0;
            r_out_valid <= 1'b0;
            r_onij_idx  <= '0;
            r_kij_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_t         <= w_t;
            r_kij       <= w_kij;
            r_o         <= w_o;
            r_p         <= w_p;
            r_wr_pend   <= w_wr_pend;
            r_inst      <= w_inst;
            r_acc_clr   <= w_acc_clr;
            r_out_valid <= w_out_valid;
            r_kij_idx   <= r_kij;
            r_busy      <= w_busy;
            r_done      <= w_done;
            // onij_idx holds its last value between passes
            if (w_out_valid)                     r_onij_idx <= r_o;
            else if (r_state == S_IDLE && i_start) r_onij_idx <= '0;
        end
    end

    assign o_inst      = r_inst;
    assign o_acc_clr   = r_acc_clr;
    assign o_out_valid = r_out_valid;
    assign o_onij_idx  = r_onij_idx;
    assign o_kij_idx   = r_kij_idx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Bench for core_inst_sequencer: directed passes with constant, stalled and random
// ofifo_valid, checked against address/event lists built from the pass description.
module tb_core_inst_sequencer;

    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ofifo_valid = 1'b1;
    logic [33:0] inst;
    logic        acc_clr, out_valid, busy, done;
    logic [4:0]  onij_idx;
    logic [3:0]  kij_idx;

    core_inst_sequencer dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_ofifo_valid(ofifo_valid),
        .o_inst(inst), .o_acc_clr(acc_clr), .o_out_valid(out_valid),
        .o_onij_idx(onij_idx), .o_kij_idx(kij_idx), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int vmode = 1;   // 0: valid low, 1: valid high, 2: random

    always @(negedge clk) begin
        #1;
        if (vmode == 0)      ofifo_valid = 1'b0;
        else if (vmode == 1) ofifo_valid = 1'b1;
        else                 ofifo_valid = 1'($urandom_range(0, 1));
    end

    // ---------------- monitor ----------------
    logic        rec = 1'b0;
    int          cyc = 0;
    logic [10:0] q_xrd[$], q_pwr[$], q_prd[$];
    int          q_clr[$], q_ov[$], q_ovi[$];
    int n_l0wr, n_load, n_exec, n_acc, n_ofrd, n_rd_viol, n_wr_viol, n_acc_viol;
    logic prev_rd = 1'b0, prev_prd = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rec) begin
            if (!inst[19] && inst[18]) q_xrd.push_back(inst[17:7]);
            if (!inst[32] && !inst[31]) q_pwr.push_back(inst[30:20]);
            if (!inst[32] && inst[31])  q_prd.push_back(inst[30:20]);
            n_l0wr += int'(inst[2]);
            n_load += int'(inst[0]);
            n_exec += int'(inst[1]);
            n_acc  += int'(inst[33]);
            n_ofrd += int'(inst[6]);
            // ofifo_rd reflects the valid sampled at the edge that produced this word
            if (inst[6] && !ofifo_valid) n_rd_viol++;
            if ((!inst[32] && !inst[31]) != prev_rd) n_wr_viol++;
            if (inst[33] != prev_prd) n_acc_viol++;
            if (acc_clr) q_clr.push_back(cyc);
            if (out_valid) begin
                q_ov.push_back(cyc);
                q_ovi.push_back(int'(onij_idx));
            end
        end
        prev_rd  = inst[6];
        prev_prd = !inst[32] && inst[31];
    end

    // ---------------- reference lists ----------------
    logic [10:0] e_xrd[$], e_pwr[$], e_prd[$];

    task automatic build_model();
        for (int k = 0; k < 9; k++) begin
            for (int t = 0; t < 8; t++)  e_xrd.push_back(11'(1024 + k * 8 + t));
            for (int t = 0; t < 36; t++) e_xrd.push_back(11'(t));
            for (int n = 0; n < 36; n++) e_pwr.push_back(11'(k * 36 + n));
        end
        for (int o = 0; o < 16; o++)
            for (int k = 0; k < 9; k++)
                e_prd.push_back(11'(k * 36 + (o / 4 + k / 3) * 6 + (o % 4 + k % 3)));
    endtask

    function automatic int first_diff(input logic [10:0] a[$], input logic [10:0] b[$]);
        int n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rec();
        q_xrd.delete(); q_pwr.delete(); q_prd.delete();
        q_clr.delete(); q_ov.delete(); q_ovi.delete();
        n_l0wr = 0; n_load = 0; n_exec = 0; n_acc = 0; n_ofrd = 0;
        n_rd_viol = 0; n_wr_viol = 0; n_acc_viol = 0;
        rec = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick(1);
            n++;
        end
        chk("done_within_budget", 64'(n < budget), 64'd1);
    endtask

    task automatic wait_exec(input int target, input int budget);
        int n = 0;
        while (n_exec < target && n < budget) begin
            tick(1);
            n++;
        end
        chk("exec_reached", 64'(n < budget), 64'd1);
    endtask

    // end-of-pass checks; called at the negedge where done is seen
    task automatic check_pass(input string name);
        int bad_gap = -1;
        chk({name, "_done_busy_low"}, 64'(busy), 64'd0);
        chk({name, "_done_inst_idle"}, 64'(inst), 64'(IDLE_WORD));
        chk({name, "_xrd_count"}, 64'(q_xrd.size()), 64'(e_xrd.size()));
        chk({name, "_xrd_seq"}, 64'(first_diff(q_xrd, e_xrd)), 64'(-1));
        if (q_xrd.size() > 44) chk({name, "_kij1_wbase"}, 64'(q_xrd[44]), 64'd1032);
        chk({name, "_pwr_count"}, 64'(q_pwr.size()), 64'd324);
        chk({name, "_pwr_seq"}, 64'(first_diff(q_pwr, e_pwr)), 64'(-1));
        chk({name, "_prd_count"}, 64'(q_prd.size()), 64'd144);
        chk({name, "_prd_seq"}, 64'(first_diff(q_prd, e_prd)), 64'(-1));
        if (q_prd.size() > 49) chk({name, "_prd_o5_k4"}, 64'(q_prd[49]), 64'd158);
        chk({name, "_l0wr"}, 64'(n_l0wr), 64'd396);
        chk({name, "_load"}, 64'(n_load), 64'd72);
        chk({name, "_exec"}, 64'(n_exec), 64'd324);
        chk({name, "_acc"}, 64'(n_acc), 64'd144);
        chk({name, "_ofrd"}, 64'(n_ofrd), 64'd324);
        chk({name, "_rd_without_valid"}, 64'(n_rd_viol), 64'd0);
        chk({name, "_wr_not_after_rd"}, 64'(n_wr_viol), 64'd0);
        chk({name, "_acc_not_after_rd"}, 64'(n_acc_viol), 64'd0);
        chk({name, "_clr_count"}, 64'(q_clr.size()), 64'd16);
        chk({name, "_ov_count"}, 64'(q_ov.size()), 64'd16);
        // out_valid falls on the 12th cycle of the window opened by acc_clr
        for (int i = 0; i < 16 && i < q_clr.size() && i < q_ov.size(); i++) begin
            if (bad_gap < 0 && (q_ov[i] - q_clr[i] != 11 || q_ovi[i] != i)) bad_gap = i;
            if (bad_gap < 0 && i > 0 && q_clr[i] - q_clr[i-1] != 12) bad_gap = i;
        end
        chk({name, "_ov_timing_idx"}, 64'(bad_gap), 64'(-1));
        tick(1);
        chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({name, "_kij_sat"}, 64'(kij_idx), 64'd8);
        chk({name, "_onij_sat"}, 64'(onij_idx), 64'd15);
        rec = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [33:0] first_word;

    initial begin
        build_model();
        first_word = IDLE_WORD;
        first_word[19] = 1'b0;
        first_word[17:7] = 11'd1024;

        // reset held for 3 cycles
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_inst", 64'(inst), 64'(IDLE_WORD));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_outs", 64'({acc_clr, out_valid, onij_idx, kij_idx}), 64'd0);

        // pass A: ofifo_valid tied high
        vmode = 1;
        tick(1);
        clear_rec();
        pulse_start();
        chk("A_busy_rise", 64'(busy), 64'd1);
        chk("A_inst_lag", 64'(inst), 64'(IDLE_WORD));
        tick(1);
        chk("A_first_xmem_word", 64'(inst), 64'(first_word));
        wait_done(5000);
        check_pass("A");

        // pass B: valid held low through OF_WAIT of kij0, then random; start mid-pass ignored
        vmode = 0;
        tick(2);
        clear_rec();
        pulse_start();
        wait_exec(36, 500);
        tick(16 + 20);
        chk("B_wait_no_ofrd", 64'(n_ofrd), 64'd0);
        chk("B_wait_no_pwr", 64'(q_pwr.size()), 64'd0);
        chk("B_wait_inst_idle", 64'(inst), 64'(IDLE_WORD));
        chk("B_wait_busy", 64'(busy), 64'd1);
        vmode = 2;
        tick(60);
        pulse_start();
        wait_done(8000);
        check_pass("B");

        // pass C: reset (with start) during EXEC of kij3, then fresh pass
        vmode = 2;
        tick(2);
        clear_rec();
        pulse_start();
        wait_exec(3 * 36 + 5, 3000);
        chk("C_in_kij3", 64'(kij_idx), 64'd3);
        reset = 1'b1;
        start = 1'b1;
        tick(1);
        reset = 1'b0;
        start = 1'b0;
        chk("C_rst_inst", 64'(inst), 64'(IDLE_WORD));
        chk("C_rst_busy", 64'(busy), 64'd0);
        chk("C_rst_kij", 64'(kij_idx), 64'd0);
        tick(3);
        chk("C_start_with_rst_ignored", 64'(busy), 64'd0);
        chk("C_idle_inst", 64'(inst), 64'(IDLE_WORD));
        clear_rec();
        pulse_start();
        tick(1);
        chk("C_restart_word", 64'(inst), 64'(first_word));
        wait_done(8000);
        check_pass("C");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
